// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit blocks:
// frame width, default bit timing and receiver state encoding.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready byte stream from the UART receiver to the SOC UART read register.
interface uart_rx_if #(
    parameter int FIFO_DEPTH = 4
);
    import uart_pkg::*;

    logic [DATA_BITS-1:0]         rx_data;
    logic                         rx_valid;
    logic                         rx_ready;
    logic [$clog2(FIFO_DEPTH):0]  rx_count;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_count,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_count,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; the head entry is always visible on head_data.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        push,
    input  logic [DATA_BITS-1:0]        push_data,
    input  logic                        pop,
    output logic [DATA_BITS-1:0]        head_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises RXD, samples each bit at its midpoint and
// queues received bytes in a FWFT FIFO drained over a valid/ready interface.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      rxd,
    uart_rx_if.master rx_bus,
    output logic      overrun,
    output logic      frame_err,
    input  logic      clear_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_C = IDX_W'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;

    uart_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;

    logic                   push, pop, frame_bad, overrun_set;
    logic                   fifo_full, fifo_empty;

    // Preset to idle-high so leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // START re-checks the line at mid start bit to reject glitches; BREAK
    // holds off re-arming until the line returns high after a bad stop bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rs) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_C) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rs;
                    if (bit_idx_q == LAST_C) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_C) begin
                    cnt_d = '0;
                    if (rs) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (rs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flags: a set event in the same cycle as clear_err takes priority.
    assign pop         = rx_bus.rx_ready && !fifo_empty;
    assign overrun_set = push && fifo_full && !pop;

    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (clear_err) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
        if (frame_bad) begin
            frame_err_d = 1'b1;
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .head_data (rx_bus.rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_bus.rx_count)
    );

    assign rx_bus.rx_valid = !fifo_empty;
    assign overrun         = overrun_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: latency, FIFO fill/overrun, framing errors,
// glitch rejection, simultaneous push/pop when full and mid-frame reset.
module tb_uart_rx;

    localparam int CPB    = 104;
    localparam int DEPTH  = 4;
    localparam int SYNC   = 2;
    localparam int HALF   = CPB / 2;
    localparam int RISE_J = HALF + SYNC + 1;

    logic clk = 1'b0;
    logic resetn;
    logic rxd;
    logic clear_err;
    logic overrun;
    logic frame_err;

    int total = 0;
    int bad   = 0;

    uart_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rxd       (rxd),
        .rx_bus    (bus),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clear_err (clear_err)
    );

    always #5 clk = ~clk;

    // All stimulus tasks start and end just after a falling clock edge.
    task automatic send_head(input logic [7:0] data);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] data);
        send_head(data);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic pop_one(output logic [7:0] d, output logic v);
        v = bus.rx_valid;
        d = bus.rx_data;
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        rxd = 1'b1;
        clear_err = 1'b0;
        bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", bus.rx_valid); end
        total++; if (bus.rx_count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", bus.rx_count); end
        total++; if (bus.rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h want 00", bus.rx_data); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_err: got %b want 0", frame_err); end
        resetn = 1'b1;
        idle_bits(1);
    endtask

    task automatic test_basic();
        logic [7:0] vals [2];
        logic [7:0] d;
        logic       v;
        vals = '{8'h55, 8'hA3};
        for (int f = 0; f < 2; f++) begin
            send_head(vals[f]);
            rxd = 1'b1;
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk);
                if (j == RISE_J - 1) begin
                    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_valid[%0d]: got %b want 0", f, bus.rx_valid); end
                end
                if (j == RISE_J) begin
                    total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid_rise[%0d]: got %b want 1", f, bus.rx_valid); end
                end
            end
            pop_one(d, v);
            total++; if (v !== 1'b1 || d !== vals[f]) begin bad++; $display("[TB] FAIL basic_pop[%0d]: got valid=%b data=%h want valid=1 data=%h", f, v, d, vals[f]); end
            total++; if (bus.rx_count !== 3'd0) begin bad++; $display("[TB] FAIL basic_count[%0d]: got %0d want 0", f, bus.rx_count); end
        end
        total++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("[TB] FAIL basic_flags: got ovr=%b ferr=%b want 0 0", overrun, frame_err); end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic       v;
        bus.rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i));
        end
        total++; if (bus.rx_count !== 3'd4) begin bad++; $display("[TB] FAIL ovr_count_full: got %0d want 4", bus.rx_count); end
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_flag: got %b want 1", overrun); end
        for (int i = 1; i <= 4; i++) begin
            pop_one(d, v);
            total++; if (v !== 1'b1 || d !== 8'(i)) begin bad++; $display("[TB] FAIL ovr_pop[%0d]: got valid=%b data=%h want valid=1 data=%h", i, v, d, 8'(i)); end
        end
        total++; if (bus.rx_count !== 3'd0 || bus.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_drained: got count=%0d valid=%b want 0 0", bus.rx_count, bus.rx_valid); end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        logic       v;
        send_head(8'h7E);
        rxd = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        total++; if (frame_err !== 1'b1) begin bad++; $display("[TB] FAIL ferr_set: got %b want 1", frame_err); end
        total++; if (bus.rx_count !== 3'd0) begin bad++; $display("[TB] FAIL ferr_count: got %0d want 0", bus.rx_count); end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        repeat (16 * CPB - 1) @(negedge clk);
        idle_bits(2);
        total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL ferr_single: got %b want 0", frame_err); end
        total++; if (bus.rx_count !== 3'd0) begin bad++; $display("[TB] FAIL ferr_no_spurious: got %0d want 0", bus.rx_count); end
        send_byte(8'h42);
        pop_one(d, v);
        total++; if (v !== 1'b1 || d !== 8'h42) begin bad++; $display("[TB] FAIL ferr_recover: got valid=%b data=%h want valid=1 data=42", v, d); end
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        logic       v;
        rxd = 1'b0;
        repeat (30) @(negedge clk);
        idle_bits(2);
        total++; if (bus.rx_count !== 3'd0 || bus.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL glitch_no_byte: got count=%0d valid=%b want 0 0", bus.rx_count, bus.rx_valid); end
        total++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("[TB] FAIL glitch_flags: got ovr=%b ferr=%b want 0 0", overrun, frame_err); end
        send_byte(8'h99);
        pop_one(d, v);
        total++; if (v !== 1'b1 || d !== 8'h99) begin bad++; $display("[TB] FAIL glitch_recover: got valid=%b data=%h want valid=1 data=99", v, d); end
    endtask

    task automatic test_full_pop();
        logic [7:0] fill [4];
        logic [7:0] expq [4];
        logic [7:0] d;
        logic       v;
        fill = '{8'h11, 8'h22, 8'h33, 8'h44};
        expq = '{8'h22, 8'h33, 8'h44, 8'h5A};
        bus.rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_byte(fill[i]);
        end
        total++; if (bus.rx_count !== 3'd4) begin bad++; $display("[TB] FAIL fullpop_prefill: got %0d want 4", bus.rx_count); end
        send_head(8'h5A);
        rxd = 1'b1;
        for (int j = 0; j < CPB; j++) begin
            @(negedge clk);
            if (j == RISE_J - 1) bus.rx_ready = 1'b1;
            if (j == RISE_J) bus.rx_ready = 1'b0;
        end
        total++; if (bus.rx_count !== 3'd4) begin bad++; $display("[TB] FAIL fullpop_count: got %0d want 4", bus.rx_count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL fullpop_overrun: got %b want 0", overrun); end
        for (int i = 0; i < 4; i++) begin
            pop_one(d, v);
            total++; if (v !== 1'b1 || d !== expq[i]) begin bad++; $display("[TB] FAIL fullpop_pop[%0d]: got valid=%b data=%h want valid=1 data=%h", i, v, d, expq[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] c3;
        logic [7:0] d;
        logic       v;
        c3 = 8'hC3;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = c3[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = c3[4];
        repeat (HALF) @(negedge clk);
        resetn = 1'b0;
        rxd = 1'b1;
        @(negedge clk);
        total++; if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0 || bus.rx_count !== 3'd0) begin bad++; $display("[TB] FAIL midrst_bus: got data=%h valid=%b count=%0d want 00 0 0", bus.rx_data, bus.rx_valid, bus.rx_count); end
        total++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("[TB] FAIL midrst_flags: got ovr=%b ferr=%b want 0 0", overrun, frame_err); end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        idle_bits(2);
        send_byte(8'h3C);
        total++; if (bus.rx_count !== 3'd1) begin bad++; $display("[TB] FAIL midrst_count: got %0d want 1", bus.rx_count); end
        pop_one(d, v);
        total++; if (v !== 1'b1 || d !== 8'h3C) begin bad++; $display("[TB] FAIL midrst_pop: got valid=%b data=%h want valid=1 data=3c", v, d); end
        total++; if (bus.rx_count !== 3'd0 || frame_err !== 1'b0) begin bad++; $display("[TB] FAIL midrst_final: got count=%0d ferr=%b want 0 0", bus.rx_count, frame_err); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_full_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for the SOC's RXD pin. Deserialises 8N1 frames into bytes and buffers them in a small FIFO. The FIFO is drained by the SOC's memory-mapped UART register through a valid/ready handshake. Sits directly upstream of the SOC's UART read path, beside the existing TXD transmitter.

Parameters:
CLKS_PER_BIT, 104, clk cycles per bit (12 MHz / 115200); must be >= 8
FIFO_DEPTH, 4, byte entries; power of two, >= 2
SYNC_STAGES, 2, RXD synchroniser flops; must be >= 2

Ports:
clk  input  1  system clock (same domain as SOC CLK)
resetn  input  1  asynchronous active-low reset
rxd  input  1  raw serial line, idle high, asynchronous to clk
rx_data  output  8  byte at FIFO head; valid only while rx_valid=1
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer pops the head when rx_valid && rx_ready
rx_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered
overrun  output  1  sticky: a complete frame arrived while the FIFO was full
frame_err  output  1  sticky: stop bit sampled low
clear_err  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async assert, sync deassert by the SOC reset logic): FSM=IDLE; FIFO empty; rx_data=0, rx_valid=0, rx_count=0, overrun=0, frame_err=0; synchroniser flops preset to 1 so reset does not produce a false start.
- rxd passes through SYNC_STAGES flops. All decisions use the synchronised value rs.
- FSM states:
  - IDLE: wait for rs=0. On 0, bit counter <= 0 and go to START.
  - START: count to CLKS_PER_BIT/2 (integer divide). If rs=1 at that point, glitch: return to IDLE with nothing recorded. Otherwise reset the counter and go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample rs into shift[bit_idx], LSB first. After bit 7 go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rs.
    - rs=1: push the byte, go to IDLE.
    - rs=0: frame_err<=1, byte discarded, go to BREAK.
  - BREAK: wait for rs=1, then go to IDLE. A line held low produces exactly one frame_err and no spurious bytes.
- Push occurs on the cycle the stop bit is sampled high. rx_valid rises on the next clk edge when the FIFO was empty. Total latency from the stop-bit midpoint on rxd is SYNC_STAGES+1 cycles.
- FIFO: first-word-fall-through. rx_data always shows the head entry.
  - Pop on rx_valid && rx_ready; rx_ready is ignored when empty.
  - Full with push and no pop in the same cycle: byte dropped, overrun<=1, contents unchanged.
  - Full with push and pop in the same cycle: both occur; count unchanged; no overrun.
  - Empty with a push: only the push occurs.
  - Pointers wrap modulo FIFO_DEPTH. rx_count tracks occupancy 0..FIFO_DEPTH.
- clear_err=1 clears both sticky flags. If a set event occurs in the same cycle, the set wins.
- Asserting resetn low mid-frame aborts the frame immediately. After release, the receiver waits in IDLE for a fresh falling edge.

Decomposition:
- Shared package uart_pkg:
  - state encoding typedef (IDLE, START, DATA, STOP, BREAK)
  - DATA_BITS=8
  - default CLKS_PER_BIT constant, also used by the TX block
- One sub-module, uart_rx_fifo: parameterised FWFT byte FIFO with push, pop, full, empty and count. The FSM and synchroniser stay in uart_rx.

Test Plan:
- Send 0x55, then 0xA3, at CLKS_PER_BIT=104 -> rx_valid rises SYNC_STAGES+1 cycles after each stop-bit midpoint; pops with rx_ready=1 return 0x55 then 0xA3; rx_count returns to 0; no flags set.
- rx_ready=0 while 5 bytes 0x01..0x05 are sent (FIFO_DEPTH=4) -> rx_count=4, overrun=1; pops return 0x01..0x04. Then clear_err=1 -> overrun=0.
- Frame 0x7E with stop bit forced low, rxd held low for 20 bit times, then high -> frame_err=1, rx_count=0. A following 0x42 frame is received correctly.
- Low glitch on rxd of 30 cycles (< CLKS_PER_BIT/2) -> FSM returns to IDLE; no byte pushed; no flags set.
- FIFO full; final stop bit sampled in the same cycle as rx_ready=1 -> count stays 4, new byte at the tail, overrun=0.
- resetn pulsed low during bit 4 of 0xC3, then a full 0x3C frame sent -> only 0x3C received; all outputs were 0 during reset.
